vga_bars: RTL and testbench

VGA_BARS -- requirements
Module: vga_bars

---
 rtl/vga_bars.sv | 186 ++++++++++++++++++
 tb/tb_vga_bars.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_bars.sv
// VGA timing generator with BARS vertical colour bars. Optional tear-free
// colour latching is enabled by defining VGA_FRAME_LATCH_EN.
module vga_bars #(
  parameter int H_VIS   = 800,
  parameter int H_FP    = 56,
  parameter int H_SYNC  = 120,
  parameter int H_BP    = 64,
  parameter int V_VIS   = 600,
  parameter int V_FP    = 37,
  parameter int V_SYNC  = 6,
  parameter int V_BP    = 23,
  parameter int HS_POL  = 1,
  parameter int VS_POL  = 1,
  parameter int BARS    = 2,
  parameter int CLK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [12*BARS-1:0]   code,
  output logic                 hsync,
  output logic                 vsync,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic                 active,
  output logic                 frame_start,
  output logic [10:0]          pix_x,
  output logic [9:0]           pix_y
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_VIS / BARS;

  localparam logic [10:0] X_VIS    = 11'(H_VIS);
  localparam logic [10:0] X_HS_ON  = 11'(H_VIS + H_FP);
  localparam logic [10:0] X_HS_OFF = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] IB_LAST  = 11'(BAR_W - 1);
  localparam logic [9:0]  Y_VIS    = 10'(V_VIS);
  localparam logic [9:0]  Y_VS_ON  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  Y_VS_OFF = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic        HS_ACT   = (HS_POL != 0);
  localparam logic        VS_ACT   = (VS_POL != 0);

  // Timing counters
  logic [3:0]  div_q, div_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [10:0] inbar_q, inbar_d;
  logic [4:0]  bar_q, bar_d;
  logic        tick;

  // Registered outputs
  logic        hsync_q, vsync_q;
  logic [3:0]  red_q, green_q, blue_q;
  logic        active_q, frame_start_q;
  logic [10:0] pix_x_q;
  logic [9:0]  pix_y_q;

  // Decode of the current counter position
  logic        vis;
  logic        hs_on, vs_on;
  logic [11:0] bar_rgb;
  logic [11:0] rgb_d;
  logic [12*BARS-1:0] code_src;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d   = tick ? 4'd0 : div_q + 4'd1;
    x_d     = x_q;
    y_d     = y_q;
    inbar_d = inbar_q;
    bar_d   = bar_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d     = '0;
        inbar_d = '0;
        bar_d   = '0;
        y_d     = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
        // Bar position advances only across the visible span, so bar_q
        // never exceeds BARS.
        if (x_q < X_VIS) begin
          if (inbar_q == IB_LAST) begin
            inbar_d = '0;
            bar_d   = bar_q + 5'd1;
          end else begin
            inbar_d = inbar_q + 11'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      inbar_q <= '0;
      bar_q   <= '0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      inbar_q <= inbar_d;
      bar_q   <= bar_d;
    end
  end

`ifdef VGA_FRAME_LATCH_EN
  // Colour codes are sampled once per frame, on the last tick of the frame.
  logic [12*BARS-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (tick && (x_q == X_LAST) && (y_q == Y_LAST)) shadow_d = code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  assign code_src = shadow_q;
`else
  assign code_src = code;
`endif

  always_comb begin
    bar_rgb = '0;
    for (int i = 0; i < BARS; i++) begin
      if (bar_q == 5'(i)) bar_rgb = code_src[12*(BARS-i)-1 -: 12];
    end
  end

  always_comb begin
    vis   = (x_q < X_VIS) && (y_q < Y_VIS);
    hs_on = (x_q >= X_HS_ON) && (x_q < X_HS_OFF);
    vs_on = (y_q >= Y_VS_ON) && (y_q < Y_VS_OFF);
    rgb_d = vis ? bar_rgb : 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
    end else begin
      // One clk wide even when ticks are several clks apart.
      frame_start_q <= tick && (x_q == 11'd0) && (y_q == 10'd0);
      if (tick) begin
        hsync_q  <= hs_on ? HS_ACT : ~HS_ACT;
        vsync_q  <= vs_on ? VS_ACT : ~VS_ACT;
        red_q    <= rgb_d[11:8];
        green_q  <= rgb_d[7:4];
        blue_q   <= rgb_d[3:0];
        active_q <= vis;
        pix_x_q  <= x_q;
        pix_y_q  <= y_q;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;

endmodule

// File: tb/tb_vga_bars.sv
// Bench for vga_bars on a tiny 14x8 raster, with CLK_DIV=1 and CLK_DIV=3
// instances side by side; honours VGA_FRAME_LATCH_EN when defined.
module tb_vga_bars;

`ifdef VGA_FRAME_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] code = 24'hF00_0F0;

  always #5 clk = ~clk;

  logic        hs1, vs1, act1, fs1;
  logic [3:0]  r1, g1, b1;
  logic [10:0] px1;
  logic [9:0]  py1;
  logic        hs3, vs3, act3, fs3;
  logic [3:0]  r3, g3, b3;
  logic [10:0] px3;
  logic [9:0]  py3;

  vga_bars #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
             .HS_POL(1), .VS_POL(1), .BARS(2), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .code(code), .hsync(hs1), .vsync(vs1), .red(r1), .green(g1), .blue(b1),
    .active(act1), .frame_start(fs1), .pix_x(px1), .pix_y(py1));

  vga_bars #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
             .HS_POL(1), .VS_POL(1), .BARS(2), .CLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .code(code), .hsync(hs3), .vsync(vs3), .red(r3), .green(g3), .blue(b3),
    .active(act3), .frame_start(fs3), .pix_x(px3), .pix_y(py3));

  logic [36:0] o1, o3;
  assign o1 = {hs1, vs1, r1, g1, b1, act1, fs1, px1, py1};
  assign o3 = {hs3, vs3, r3, g3, b3, act3, fs3, px3, py3};

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // e = clk edges since reset release; a pixel tick falls on every d-th edge,
  // and after k ticks the outputs show raster position k-1 (mod 112).
  int          e = 0;
  logic [23:0] lc1, sh1, lc3, sh3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e   <= 0;
      lc1 <= '0; sh1 <= '0;
      lc3 <= '0; sh3 <= '0;
    end else begin
      e   <= e + 1;
      lc1 <= code;
      if ((e % 112) == 111) sh1 <= code;
      if (((e + 1) % 3) == 0) begin
        lc3 <= code;
        if ((((e + 1) / 3 - 1) % 112) == 111) sh3 <= code;
      end
    end
  end

  function automatic logic [36:0] model_out(input int d, input int ec, input logic [23:0] cc);
    int k, p, x, y;
    logic vis, hs, vs, fs;
    logic [11:0] c;
    if (ec < d) return 37'd0;
    k   = ec / d;
    p   = (k - 1) % 112;
    x   = p % 14;
    y   = p / 14;
    vis = (x < 8) && (y < 4);
    hs  = (x >= 10) && (x < 13);
    vs  = (y >= 5) && (y < 7);
    fs  = ((ec % d) == 0) && (p == 0);
    c   = (x < 4) ? cc[23:12] : cc[11:0];
    if (!vis) c = 12'h000;
    return {hs, vs, c, vis, fs, 11'(x), 10'(y)};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [36:0] x1, x3;
    x1 = model_out(1, e, LATCH ? sh1 : lc1);
    x3 = model_out(3, e, LATCH ? sh3 : lc3);
    n_total++;
    if (o1 === x1) n_pass++;
    else $display("FAIL cycle_div1: got %h expected %h (t=%0t)", o1, x1, $time);
    n_total++;
    if (o3 === x3) n_pass++;
    else $display("FAIL cycle_div3: got %h expected %h (t=%0t)", o3, x3, $time);
  end

  // ---------------- directed stimulus ----------------
  int ne = 0;
  int hs_line = 0, hs_cnt = 0, vs_cnt = 0, act_cnt = 0, fs_cnt = 0;
  int fs3_first = -1, fs3_second = -1;

  task automatic step();
    @(posedge clk);
    #2;
    ne++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_div1"}, 64'(o1), 64'd0);
    chk({tag, "_div3"}, 64'(o3), 64'd0);
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #2; end
    chk_reset("reset_init");
    rst_n = 1'b1;
    ne    = 0;

    while (ne < 371) begin
      step();
      if (ne <= 14 && hs1) hs_line++;
      if (ne <= 224) begin
        if (hs1)  hs_cnt++;
        if (vs1)  vs_cnt++;
        if (act1) act_cnt++;
        if (fs1)  fs_cnt++;
      end
      if (fs3) begin
        if (fs3_first < 0) fs3_first = ne;
        else if (fs3_second < 0) fs3_second = ne;
      end
      case (ne)
        1: begin
          chk("first_fs", 64'(fs1), 64'd1);
          chk("first_xy", 64'({px1, py1}), 64'd0);
          chk("first_red", 64'(r1), LATCH ? 64'h0 : 64'hF);
          chk("first_active", 64'(act1), 64'd1);
          chk("div3_no_fs_yet", 64'(fs3), 64'd0);
        end
        3:  chk("div3_first_fs", 64'(fs3), 64'd1);
        5: begin
          chk("bar1_green", 64'(g1), LATCH ? 64'h0 : 64'hF);
          chk("bar1_red", 64'(r1), 64'h0);
          chk("div3_hold_x", 64'(px3), 64'd0);
        end
        6:  chk("div3_next_x", 64'(px3), 64'd1);
        9: begin
          chk("porch_black", 64'({r1, g1, b1}), 64'h000);
          chk("porch_inactive", 64'(act1), 64'd0);
          chk("porch_raw_x", 64'(px1), 64'd8);
        end
        11: chk("hsync_x10", 64'(hs1), 64'd1);
        14: begin
          chk("hsync_line_len", 64'(hs_line), 64'd3);
          chk("line_last_x", 64'(px1), 64'd13);
        end
        15: chk("line_wrap_xy", 64'({px1, py1}), 64'({11'd0, 10'd1}));
        224: begin
          chk("hsync_2frames", 64'(hs_cnt), 64'd48);
          chk("vsync_2frames", 64'(vs_cnt), 64'd56);
          chk("active_2frames", 64'(act_cnt), 64'd64);
          chk("fs_2frames", 64'(fs_cnt), 64'd2);
        end
        240: code = 24'h00F_00F;
        241: chk("code_change", 64'({r1, g1, b1}), LATCH ? 64'hF00 : 64'h00F);
        337: begin
          chk("new_frame_fs", 64'(fs1), 64'd1);
          chk("new_frame_bar0", 64'({r1, g1, b1}), 64'h00F);
        end
        340: chk("div3_fs_width", 64'(fs3), 64'd0);
        341: chk("new_frame_bar1", 64'({r1, g1, b1}), 64'h00F);
        371: chk("pre_reset_xy", 64'({px1, py1}), 64'({11'd6, 10'd2}));
        default: ;
      endcase
    end
    chk("div3_frame_period", 64'(fs3_second - fs3_first), 64'd336);

    // Mid-frame reset at pixel (6,2), held low for two clks.
    rst_n = 1'b0;
    #1;
    chk_reset("reset_abort");
    repeat (2) begin
      @(posedge clk); #2;
      chk_reset("reset_held");
    end
    rst_n = 1'b1;
    ne    = 0;
    step();
    chk("restart_fs", 64'(fs1), 64'd1);
    chk("restart_xy", 64'({px1, py1}), 64'd0);
    step(); step();
    chk("restart_div3_fs", 64'(fs3), 64'd1);
    repeat (400) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
